dco_code_driver: RTL

Synthesizable, parametrised driver for the thermometer-coded DCO tuning bank. It converts a binary tuning word with integer and fraction parts into a registered, contiguous thermometer vector. The word is rate-limited (slewed), range-clamped and optionally sigma-delta dithered. It supports FSK operation by switching between two tuning words. It sits between the ADPLL loop filter / FSK modulator and the DCO coarse pins, and replaces direct drive of the 128 coarse lines.

---
 rtl/dco_ctrl_pkg.sv | 19 +
 rtl/therm_decoder.sv | 33 +++
 rtl/dco_code_driver.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/dco_ctrl_pkg.sv
// Shared constants for the DCO code driver: mode encodings, FSM states and
// the tuning-word width helper.
package dco_ctrl_pkg;

    localparam logic [1:0] MODE_DIRECT = 2'd0;
    localparam logic [1:0] MODE_FSK    = 2'd1;
    localparam logic [1:0] MODE_HOLD   = 2'd2;

    typedef enum logic [1:0] {
        ST_SETTLED = 2'd0,
        ST_SLEW    = 2'd1,
        ST_HOLD    = 2'd2
    } dco_state_e;

    function automatic int word_w(input int code_w, input int frac_w);
        return code_w + frac_w;
    endfunction

endpackage

// File: rtl/therm_decoder.sv
// Registered binary-to-thermometer decoder: bit k of therm_o is set iff k < level_i.
module therm_decoder #(
    parameter int THERM_W   = 128,
    parameter int CODE_W    = $clog2(THERM_W + 1),
    parameter int RST_LEVEL = 1
) (
    input  logic                clk,
    input  logic                reset_,
    input  logic [CODE_W-1:0]   level_i,
    output logic [THERM_W-1:0]  therm_o
);

    function automatic logic [THERM_W-1:0] decode(input logic [CODE_W-1:0] lvl);
        logic [THERM_W-1:0] t;
        for (int k = 0; k < THERM_W; k++) begin
            t[k] = (k < int'(lvl));
        end
        return t;
    endfunction

    logic [THERM_W-1:0] therm_q;

    always_ff @(posedge clk) begin
        if (!reset_) begin
            therm_q <= decode(CODE_W'(RST_LEVEL));
        end else begin
            therm_q <= decode(level_i);
        end
    end

    assign therm_o = therm_q;

endmodule

// File: rtl/dco_code_driver.sv
// Tuning-word to thermometer driver for the DCO coarse bank: clamps, slews and
// optionally sigma-delta dithers the fraction before decoding.
module dco_code_driver
    import dco_ctrl_pkg::*;
#(
    parameter int THERM_W   = 128,
    parameter int CODE_W    = $clog2(THERM_W + 1),
    parameter int FRAC_W    = 4,
    parameter int MAX_STEP  = 4,
    parameter int MIN_LEVEL = 1
) (
    input  logic                       clk,
    input  logic                       reset_,
    input  logic                       en,
    input  logic [1:0]                 mode,
    input  logic [CODE_W+FRAC_W-1:0]   word0,
    input  logic [CODE_W+FRAC_W-1:0]   word1,
    input  logic                       fsk_bit,
    input  logic                       dither_en,
    output logic [THERM_W-1:0]         therm_out,
    output logic [CODE_W-1:0]          level,
    output logic                       slewing,
    output logic                       clamp
);

    localparam int WORD_W = word_w(CODE_W, FRAC_W);

    localparam logic [WORD_W-1:0] LO_W    = WORD_W'(MIN_LEVEL << FRAC_W);
    localparam logic [WORD_W-1:0] HI_W    = WORD_W'(THERM_W << FRAC_W);
    localparam logic [WORD_W-1:0] STEP_W  = WORD_W'(MAX_STEP << FRAC_W);
    localparam logic [CODE_W:0]   LVL_MAX = (CODE_W + 1)'(THERM_W);

    logic [WORD_W-1:0] target_q, target_d;
    logic [WORD_W-1:0] acc_q, acc_d;
    logic [FRAC_W-1:0] sd_acc_q, sd_acc_d;
    logic [CODE_W-1:0] level_q, level_d;
    logic              clamp_q, clamp_d;
    logic              slewing_q;
    dco_state_e        state_q;

    logic              active;
    logic [WORD_W-1:0] sel_word, clamp_word, delta, slew_acc;
    logic              word_oob;
    logic [FRAC_W:0]   sd_sum;
    logic              carry;
    logic [CODE_W:0]   lvl_sum;

    always_comb begin
        active   = (mode == MODE_DIRECT) || (mode == MODE_FSK);
        sel_word = (mode == MODE_FSK && fsk_bit) ? word1 : word0;

        clamp_word = sel_word;
        word_oob   = 1'b0;
        if (sel_word < LO_W) begin
            clamp_word = LO_W;
            word_oob   = 1'b1;
        end else if (sel_word > HI_W) begin
            clamp_word = HI_W;
            word_oob   = 1'b1;
        end

        // Slew is measured from the current acc, so a retarget mid-slew continues smoothly.
        if (clamp_word >= acc_q) begin
            delta    = clamp_word - acc_q;
            slew_acc = (delta <= STEP_W) ? clamp_word : acc_q + STEP_W;
        end else begin
            delta    = acc_q - clamp_word;
            slew_acc = (delta <= STEP_W) ? clamp_word : acc_q - STEP_W;
        end

        target_d = target_q;
        acc_d    = acc_q;
        clamp_d  = clamp_q;
        if (active && en) begin
            target_d = clamp_word;
            acc_d    = slew_acc;
            clamp_d  = word_oob;
        end

        sd_sum   = {1'b0, sd_acc_q} + {1'b0, acc_q[FRAC_W-1:0]};
        sd_acc_d = sd_acc_q;
        carry    = 1'b0;
        if (active) begin
            if (dither_en) begin
                sd_acc_d = sd_sum[FRAC_W-1:0];
                carry    = sd_sum[FRAC_W];
            end else begin
                sd_acc_d = '0;
            end
        end

        lvl_sum = {1'b0, acc_q[WORD_W-1:FRAC_W]} + {{CODE_W{1'b0}}, carry};
        level_d = level_q;
        if (active) begin
            level_d = (lvl_sum > LVL_MAX) ? LVL_MAX[CODE_W-1:0] : lvl_sum[CODE_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_) begin
            target_q <= LO_W;
            acc_q    <= LO_W;
            sd_acc_q <= '0;
            level_q  <= CODE_W'(MIN_LEVEL);
            clamp_q  <= 1'b0;
        end else begin
            target_q <= target_d;
            acc_q    <= acc_d;
            sd_acc_q <= sd_acc_d;
            level_q  <= level_d;
            clamp_q  <= clamp_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_) begin
            state_q   <= ST_SETTLED;
            slewing_q <= 1'b0;
        end else if (!active) begin
            state_q   <= ST_HOLD;
            slewing_q <= (acc_q != target_q);
        end else begin
            case (state_q)
                ST_SETTLED: begin
                    state_q   <= (acc_q != target_q) ? ST_SLEW : ST_SETTLED;
                    slewing_q <= (acc_q != target_q);
                end
                ST_SLEW: begin
                    state_q   <= (acc_q == target_q) ? ST_SETTLED : ST_SLEW;
                    slewing_q <= (acc_q != target_q);
                end
                default: begin
                    state_q   <= (acc_q != target_q) ? ST_SLEW : ST_SETTLED;
                    slewing_q <= (acc_q != target_q);
                end
            endcase
        end
    end

    therm_decoder #(
        .THERM_W  (THERM_W),
        .CODE_W   (CODE_W),
        .RST_LEVEL(MIN_LEVEL)
    ) u_therm_decoder (
        .clk    (clk),
        .reset_ (reset_),
        .level_i(level_d),
        .therm_o(therm_out)
    );

    assign level   = level_q;
    assign slewing = slewing_q;
    assign clamp   = clamp_q;

endmodule
